wb_uart8_lite: RTL and testbench

WB_UART8_LITE -- requirements
Module: wb_uart8_lite

---
 rtl/wb_uart8_lite_if.sv | 25 ++
 rtl/wb_uart8_lite.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_wb_uart8_lite.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart8_lite_if.sv
// Wishbone B3 classic slave bus bundle for wb_uart8_lite.
// Signal names keep the _i/_o suffixes as seen from the UART slave.
interface wb_uart8_lite_if;
   logic [31:0] wb_adr_i;
   logic [7:0]  wb_dat_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [7:0]  wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/wb_uart8_lite.sv
// Wishbone-attached 8N1 UART: TX FIFO + transmitter, optional receiver.
// Define WB_UART8_LITE_RX_EN to build the receiver; otherwise RBR and RX status read 0.
module wb_uart8_lite #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TX_FIFO_AW   = 4
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_ni,
   wb_uart8_lite_if.slave wb,
   output logic           tx_o,
   input  logic           rx_i
);

   localparam int                  DEPTH           = 1 << TX_FIFO_AW;
   localparam logic [15:0]         BIT_RELOAD      = 16'(CLKS_PER_BIT - 1);
   localparam logic [TX_FIFO_AW:0] FIFO_FULL_COUNT = (TX_FIFO_AW + 1)'(DEPTH);
   localparam logic [2:0]          ADR_DATA        = 3'd0;
   localparam logic [2:0]          ADR_LSR         = 3'd5;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // ------------------------------------------------------------------
   // Bus handshake
   // ------------------------------------------------------------------
   logic       access;
   logic       ack;
   logic       xfer;
   logic       bus_wr;
   logic       bus_rd;
   logic [2:0] adr_lo;

   assign access = wb.wb_cyc_i & wb.wb_stb_i;
   assign adr_lo = wb.wb_adr_i[2:0];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) ack <= 1'b0;
      else            ack <= access & ~ack;
   end

   assign xfer   = ack & access;
   assign bus_wr = xfer & wb.wb_we_i;
   assign bus_rd = xfer & ~wb.wb_we_i;

   assign wb.wb_ack_o = ack;
   assign wb.wb_err_o = 1'b0;
   assign wb.wb_rty_o = 1'b0;

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]            fifo_mem [DEPTH];
   logic [TX_FIFO_AW-1:0] wr_ptr;
   logic [TX_FIFO_AW-1:0] rd_ptr;
   logic [TX_FIFO_AW:0]   fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  tx_pop;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
   assign push       = bus_wr & (adr_lo == ADR_DATA) & ~fifo_full;

   // NOTE: storage has no reset; fifo_count alone decides which entries are valid.
   always_ff @(posedge wb_clk_i) begin
      if (push) fifo_mem[wr_ptr] <= wb.wb_dat_i;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, tx_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // TX FSM
   // ------------------------------------------------------------------
   tx_state_t   tx_state;
   tx_state_t   tx_next;
   logic [15:0] tx_baud;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_baud_done;

   assign tx_baud_done = (tx_baud == 16'd0);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) tx_state <= TX_IDLE;
      else            tx_state <= tx_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!fifo_empty) begin
               tx_pop  = 1'b1;
               tx_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_baud_done) tx_next = TX_DATA;
         end
         TX_DATA: begin
            if (tx_baud_done && (tx_bit == 3'd7)) tx_next = TX_STOP;
         end
         TX_STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (tx_baud_done) begin
               if (!fifo_empty) begin
                  tx_pop  = 1'b1;
                  tx_next = TX_START;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         tx_baud  <= BIT_RELOAD;
         tx_bit   <= 3'd0;
         tx_shift <= 8'hFF;
      end else if (tx_pop) begin
         tx_baud  <= BIT_RELOAD;
         tx_bit   <= 3'd0;
         tx_shift <= fifo_mem[rd_ptr];
      end else if (tx_state != TX_IDLE) begin
         if (tx_baud_done) begin
            tx_baud <= BIT_RELOAD;
            if (tx_state == TX_DATA) begin
               tx_shift <= {1'b1, tx_shift[7:1]};
               tx_bit   <= tx_bit + 3'd1;
            end
         end else begin
            tx_baud <= tx_baud - 16'd1;
         end
      end
   end

   // Decoded straight from state so reset forces the line high asynchronously.
   always_comb begin
      tx_o = 1'b1;
      case (tx_state)
         TX_START: tx_o = 1'b0;
         TX_DATA:  tx_o = tx_shift[0];
         default:  tx_o = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Receiver and RX status
   // ------------------------------------------------------------------
   logic [7:0] rbr;
   logic       data_ready;
   logic       overrun;
   logic       framing_err;
   logic       unused_bits;

`ifdef WB_UART8_LITE_RX_EN
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);

   rx_state_t   rx_state;
   rx_state_t   rx_next;
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_prev;
   logic [15:0] rx_baud;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_baud_done;
   logic        rx_frame_done;

   assign unused_bits  = ^{wb.wb_adr_i[31:3], wb.wb_cti_i, wb.wb_bte_i};
   assign rx_baud_done = (rx_baud == 16'd0);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) rx_state <= RX_IDLE;
      else            rx_state <= rx_next;
   end

   always_comb begin
      rx_next       = rx_state;
      rx_frame_done = 1'b0;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
         RX_START: if (rx_baud_done) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_baud_done && (rx_bit == 3'd7)) rx_next = RX_STOP;
         RX_STOP: begin
            if (rx_baud_done) begin
               rx_frame_done = 1'b1;
               rx_next       = rx_sync ? RX_IDLE : RX_BREAK;
            end
         end
         RX_BREAK: if (rx_sync) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   // Idle keeps the half-bit count preloaded so the start check lands mid-bit.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rx_baud  <= HALF_RELOAD;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
      end else if (rx_state == RX_IDLE) begin
         rx_baud <= HALF_RELOAD;
         rx_bit  <= 3'd0;
      end else if (rx_state inside {RX_START, RX_DATA, RX_STOP}) begin
         if (rx_baud_done) begin
            rx_baud <= BIT_RELOAD;
            if (rx_state == RX_DATA) begin
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_bit   <= rx_bit + 3'd1;
            end
         end else begin
            rx_baud <= rx_baud - 16'd1;
         end
      end
   end

   // Any completed frame that finds data_ready still set is an overrun; new events beat read-clears.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rbr         <= 8'h00;
         data_ready  <= 1'b0;
         overrun     <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         if (bus_rd && (adr_lo == ADR_DATA)) data_ready <= 1'b0;
         if (bus_rd && (adr_lo == ADR_LSR)) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
         end
         if (rx_frame_done) begin
            if (data_ready) overrun <= 1'b1;
            if (rx_sync) begin
               rbr        <= rx_shift;
               data_ready <= 1'b1;
            end else begin
               framing_err <= 1'b1;
            end
         end
      end
   end
`else
   assign unused_bits = ^{wb.wb_adr_i[31:3], wb.wb_cti_i, wb.wb_bte_i, rx_i};
   assign rbr         = 8'h00;
   assign data_ready  = 1'b0;
   assign overrun     = 1'b0;
   assign framing_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Register read path
   // ------------------------------------------------------------------
   logic [7:0] lsr;
   logic [7:0] rd_data;

   assign lsr = {1'b0, fifo_empty & (tx_state == TX_IDLE), fifo_empty, 1'b0,
                 framing_err, 1'b0, overrun, data_ready};

   always_comb begin
      rd_data = 8'h00;
      if (bus_rd) begin
         case (adr_lo)
            ADR_DATA: rd_data = rbr;
            ADR_LSR:  rd_data = lsr;
            default:  rd_data = 8'h00;
         endcase
      end
   end

   assign wb.wb_dat_o = rd_data;

endmodule

// File: tb/tb_wb_uart8_lite.sv
// Directed bench for wb_uart8_lite with CLKS_PER_BIT=4 and a 16-deep TX FIFO.
// Receiver checks are compiled in when WB_UART8_LITE_RX_EN is defined.
module tb_wb_uart8_lite;
   localparam int CPB = 4;
   localparam int AW  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic rx    = 1'b1;
   logic tx;
   int   checks = 0;
   int   errors = 0;

   wb_uart8_lite_if bus ();

   wb_uart8_lite #(
      .CLKS_PER_BIT(CPB),
      .TX_FIFO_AW  (AW)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .wb       (bus),
      .tx_o     (tx),
      .rx_i     (rx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [7:0]  wdat;
      logic [7:0]  exp;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [7:0] wdat,
                            output logic [7:0] rdat, input string tag);
      int wait_cnt;
      @(posedge clk); #1;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = wdat;
      bus.wb_we_i  = we;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      @(negedge clk);
      check({tag, " ack_low"}, bus.wb_ack_o, 1'b0);
      check({tag, " dat_idle"}, bus.wb_dat_o, 8'h00);
      @(negedge clk);
      wait_cnt = 0;
      while (bus.wb_ack_o !== 1'b1 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      check({tag, " ack_latency"}, wait_cnt, 0);
      rdat = bus.wb_dat_o;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      @(negedge clk);
      check({tag, " ack_pulse"}, bus.wb_ack_o, 1'b0);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [7:0] wdat, input string tag);
      logic [7:0] rd;
      wb_access(1'b1, adr, wdat, rd, tag);
   endtask

   task automatic wb_read(input logic [31:0] adr, input logic [7:0] exp, input string tag);
      logic [7:0] rd;
      wb_access(1'b0, adr, 8'h00, rd, tag);
      check(tag, rd, exp);
   endtask

   // Strobe held high: one write completes every two cycles.
   task automatic wb_burst(input logic [7:0] first, input int n);
      @(posedge clk); #1;
      bus.wb_adr_i = 32'h0;
      bus.wb_we_i  = 1'b1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      for (int k = 0; k < n; k++) begin
         bus.wb_dat_i = first + 8'(k);
         @(negedge clk);
         check($sformatf("burst%0d ack_low", k), bus.wb_ack_o, 1'b0);
         @(negedge clk);
         check($sformatf("burst%0d ack", k), bus.wb_ack_o, 1'b1);
         @(posedge clk); #1;
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wait_fall(input string tag, output bit ok);
      int wait_cnt;
      wait_cnt = 0;
      @(negedge clk);
      while (tx !== 1'b0 && wait_cnt < 400) begin
         @(negedge clk);
         wait_cnt++;
      end
      ok = (tx === 1'b0);
      if (!ok) check({tag, " start_timeout"}, tx, 1'b0);
   endtask

   // Checks every cycle of a frame; when find_start is 0 the frame must begin on the next cycle.
   task automatic check_frame(input logic [7:0] b, input bit find_start, input string tag);
      logic [9:0] bits;
      bit         ok;
      bits = {1'b1, b, 1'b0};
      if (find_start) begin
         wait_fall(tag, ok);
         if (!ok) return;
      end
      for (int s = 0; s < 10 * CPB; s++) begin
         if (s > 0 || !find_start) @(negedge clk);
         check($sformatf("%s bit%0d", tag, s / CPB), tx, bits[s / CPB]);
      end
   endtask

   task automatic tx_stays_high(input int n, input string tag);
      int lows;
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check(tag, lows, 0);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[14];
      bit   ok;

      vecs[0]  = '{1'b0, 32'h0000_0005, 8'h00, 8'h60, "lsr_reset"};
      vecs[1]  = '{1'b0, 32'h0000_0000, 8'h00, 8'h00, "rbr_reset"};
      vecs[2]  = '{1'b0, 32'h0000_0001, 8'h00, 8'h00, "rd_adr1"};
      vecs[3]  = '{1'b1, 32'h0000_0001, 8'hFF, 8'h00, "wr_adr1"};
      vecs[4]  = '{1'b0, 32'h0000_0001, 8'h00, 8'h00, "rd_adr1_again"};
      vecs[5]  = '{1'b1, 32'h0000_0003, 8'h80, 8'h00, "wr_adr3"};
      vecs[6]  = '{1'b0, 32'h0000_0003, 8'h00, 8'h00, "rd_adr3"};
      vecs[7]  = '{1'b1, 32'h0000_0007, 8'h55, 8'h00, "wr_adr7"};
      vecs[8]  = '{1'b0, 32'h0000_0007, 8'h00, 8'h00, "rd_adr7"};
      vecs[9]  = '{1'b0, 32'h0000_0006, 8'h00, 8'h00, "rd_adr6"};
      vecs[10] = '{1'b0, 32'hFFFF_FFF5, 8'h00, 8'h60, "lsr_alias"};
      vecs[11] = '{1'b0, 32'h0000_0004, 8'h00, 8'h00, "rd_adr4"};
      vecs[12] = '{1'b0, 32'h0000_0008, 8'h00, 8'h00, "rbr_alias"};
      vecs[13] = '{1'b0, 32'h0000_0005, 8'h00, 8'h60, "lsr_after_stray"};

      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_cti_i = '0;
      bus.wb_bte_i = '0;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset tx", tx, 1'b1);
      check("reset ack", bus.wb_ack_o, 1'b0);
      check("reset dat", bus.wb_dat_o, 8'h00);
      rst_n = 1'b1;

      // Register map and stray accesses.
      for (int i = 0; i < 14; i++) begin
         logic [7:0] rd;
         wb_access(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd, vecs[i].name);
         check(vecs[i].name, rd, vecs[i].exp);
      end

      // Single frame 0xA5, LSR busy mid-frame and idle afterwards.
      fork
         begin
            wb_write(32'h0, 8'hA5, "a5_wr");
            repeat (8) @(posedge clk);
            wb_read(32'h5, 8'h20, "lsr_busy");
         end
         check_frame(8'hA5, 1'b1, "a5");
      join
      wb_read(32'h5, 8'h60, "a5_lsr_after");

      // A primer frame is in flight while 17 bytes arrive; the 17th finds the FIFO full.
      fork
         begin
            wb_write(32'h0, 8'h5A, "primer_wr");
            wb_burst(8'h00, 17);
         end
         begin
            check_frame(8'h5A, 1'b1, "primer");
            for (int k = 0; k < 16; k++) check_frame(8'(k), 1'b0, $sformatf("q%0d", k));
         end
      join
      tx_stays_high(60, "no_byte_0x10");
      wb_read(32'h5, 8'h60, "burst_lsr_after");

      // Reset during data bit 3 drops the line and flushes the queue.
      fork
         begin
            wb_write(32'h0, 8'h00, "rst_wr0");
            wb_write(32'h0, 8'h11, "rst_wr1");
         end
         begin
            wait_fall("rst_frame", ok);
            repeat (17) @(negedge clk);
            check("rst tx_bit3", tx, 1'b0);
         end
      join
      #3 rst_n = 1'b0;
      #1;
      check("rst tx_async", tx, 1'b1);
      check("rst ack", bus.wb_ack_o, 1'b0);
      check("rst dat", bus.wb_dat_o, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      wb_read(32'h5, 8'h60, "rst_lsr_after");
      tx_stays_high(50, "rst_queue_lost");

`ifdef WB_UART8_LITE_RX_EN
      send_rx(8'h3C, 1'b1);
      repeat (4) @(posedge clk);
      wb_read(32'h5, 8'h61, "rx_lsr_ready");
      wb_read(32'h0, 8'h3C, "rx_rbr");
      wb_read(32'h5, 8'h60, "rx_lsr_cleared");

      send_rx(8'h81, 1'b1);
      send_rx(8'h42, 1'b0);
      repeat (6) @(posedge clk);
      wb_read(32'h5, 8'h6B, "rx_lsr_oe_fe");
      wb_read(32'h5, 8'h61, "rx_lsr_second");
      wb_read(32'h0, 8'h81, "rx_rbr_kept");
      wb_read(32'h5, 8'h60, "rx_lsr_final");

      @(posedge clk); #1;
      rx = 1'b0;
      @(posedge clk); #1;
      rx = 1'b1;
      repeat (12) @(posedge clk);
      wb_read(32'h5, 8'h60, "rx_false_start");
`else
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         rx = ((i % 3) == 0);
      end
      rx = 1'b1;
      send_rx(8'h3C, 1'b1);
      repeat (6) @(posedge clk);
      wb_read(32'h5, 8'h60, "norx_lsr");
      wb_read(32'h0, 8'h00, "norx_rbr");
      wb_read(32'h5, 8'h60, "norx_lsr_again");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
